// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: issues PC requests, tracks in-flight responses and buffers fetched instructions.
// Optional FETCH_ALIGN_CHECK_EN: misaligned PCs become exception entries (out_exc) instead of memory requests.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] next_PC,
    input  logic        redirect,
    output logic [31:0] F_PC,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_instr,
    output logic        out_valid,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        out_exc,
`endif
    output logic [31:0] out_instr,
    output logic [31:0] out_PC,
    input  logic        out_ready
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [1:0]  outstanding;
    logic [1:0]  q_count;
    logic [1:0]  drop_cnt;
    logic [1:0]  drop_d;
    logic [0:0]  state;
    logic [0:0]  state_d;
    logic        pend_wr;
    logic        pend_rd;
    logic        q_wr;
    logic        q_rd;
    logic [31:0] pend_addr [2];
    logic [31:0] q_pc      [QDEPTH];
    logic [31:0] q_instr   [QDEPTH];
`ifdef FETCH_ALIGN_CHECK_EN
    logic        q_exc     [QDEPTH];
`endif
    logic        slot_free;
    logic        req_fire;
    logic        exc_fire;
    logic        rsp_keep;
    logic        q_push;
    logic        q_pop;
    logic [31:0] push_pc;
    logic [31:0] push_instr;

    // NOTE: every signal gets a value on every path through this block, so no latch can be inferred.
    always_comb begin
        slot_free = ({1'b0, outstanding} + {1'b0, q_count}) < 3'd2;
`ifdef FETCH_ALIGN_CHECK_EN
        // A misaligned fetch waits for older responses so the exception entry stays in program order.
        imem_req_valid = reset_n && slot_free && !redirect && (F_PC[1:0] == 2'b00);
        exc_fire       = reset_n && slot_free && !redirect && (F_PC[1:0] != 2'b00)
                         && (outstanding == 2'd0);
`else
        imem_req_valid = reset_n && slot_free && !redirect;
        exc_fire       = 1'b0;
`endif
        req_fire   = imem_req_valid && imem_req_ready;
        rsp_keep   = imem_rsp_valid && (state == RUN) && !redirect;
        q_push     = rsp_keep || exc_fire;
        q_pop      = out_valid && out_ready;
        push_pc    = exc_fire ? F_PC : pend_addr[pend_rd];
        push_instr = exc_fire ? 32'h0000_0000 : imem_rsp_instr;

        if (redirect)
            drop_d = outstanding - 2'(imem_rsp_valid);
        else if (imem_rsp_valid && (state == DRAIN))
            drop_d = drop_cnt - 2'd1;
        else
            drop_d = drop_cnt;
        state_d = (drop_d != 2'd0) ? DRAIN : RUN;
    end

    assign imem_req_addr = F_PC;
    assign out_valid     = (q_count != 2'd0);
    assign out_PC        = q_pc[q_rd];
    assign out_instr     = q_instr[q_rd];
`ifdef FETCH_ALIGN_CHECK_EN
    assign out_exc       = q_exc[q_rd];
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            F_PC        <= RESET_PC;
            outstanding <= 2'd0;
            q_count     <= 2'd0;
            drop_cnt    <= 2'd0;
            state       <= RUN;
            pend_wr     <= 1'b0;
            pend_rd     <= 1'b0;
            q_wr        <= 1'b0;
            q_rd        <= 1'b0;
        end else begin
            if (redirect || req_fire || exc_fire)
                F_PC <= next_PC;
            outstanding <= outstanding + 2'(req_fire) - 2'(imem_rsp_valid);
            if (req_fire)
                pend_wr <= ~pend_wr;
            if (imem_rsp_valid)
                pend_rd <= ~pend_rd;
            drop_cnt <= drop_d;
            state    <= state_d;
            if (redirect) begin
                q_count <= 2'd0;
                q_rd    <= q_wr;
            end else begin
                q_count <= q_count + 2'(q_push) - 2'(q_pop);
                if (q_push)
                    q_wr <= ~q_wr;
                if (q_pop)
                    q_rd <= ~q_rd;
            end
        end
    end

    // NOTE: storage arrays carry no reset; the pointers and counts alone decide what is valid.
    always_ff @(posedge clk) begin
        if (req_fire)
            pend_addr[pend_wr] <= F_PC;
        if (q_push && !redirect) begin
            q_pc[q_wr]    <= push_pc;
            q_instr[q_wr] <= push_instr;
`ifdef FETCH_ALIGN_CHECK_EN
            q_exc[q_wr]   <= exc_fire;
`endif
        end
    end

    // Flow control must keep in-flight requests plus buffered entries within the queue capacity.
    assert property (@(posedge clk) disable iff (!reset_n)
        ({1'b0, outstanding} + {1'b0, q_count}) <= 3'd2)
        else $error("pc_fetch_unit: outstanding + queue_count exceeds 2");

endmodule
